// File: rtl/framebuffer_dram_arbiter_if.sv
// framebuffer_dram_arbiter_if: requester-side and memory-controller-side signals of framebuffer_dram_arbiter
interface framebuffer_dram_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128,
  parameter int MAX_OUTSTANDING = 4
);
  logic rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic rd_urgent;
  logic rd_req_ready;
  logic wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic wr_req_ready;
  logic [DATA_W-1:0] wr_data;
  logic wr_data_valid;
  logic wr_data_last;
  logic wr_data_ready;
  logic mem_cmd_valid;
  logic mem_cmd_write;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic mem_cmd_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_wdata_valid;
  logic mem_wdata_last;
  logic mem_wdata_ready;
  logic mem_rdata_valid;
  logic mem_rdata_last;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding;
  logic err_wlast;
  modport slave (
    input rd_req_valid, rd_req_addr, rd_urgent, wr_req_valid, wr_req_addr, wr_data, wr_data_valid,
          wr_data_last, mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata_last,
    output rd_req_ready, wr_req_ready, wr_data_ready, mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
           mem_wdata, mem_wdata_valid, mem_wdata_last, rd_outstanding, err_wlast
  );
  modport master (
    output rd_req_valid, rd_req_addr, rd_urgent, wr_req_valid, wr_req_addr, wr_data, wr_data_valid,
           wr_data_last, mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata_last,
    input rd_req_ready, wr_req_ready, wr_data_ready, mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
          mem_wdata, mem_wdata_valid, mem_wdata_last, rd_outstanding, err_wlast
  );
endinterface

// File: rtl/framebuffer_dram_arbiter.sv
// framebuffer_dram_arbiter: shares one DRAM burst port between display reads and write-back writes.
// Define FB_ARB_PERF_EN to add saturating perf counters (perf_rd_bursts, perf_wr_bursts, perf_urgent_wait).
module framebuffer_dram_arbiter #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 128,
  parameter int BURST_LEN = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  framebuffer_dram_arbiter_if.slave bus
`ifdef FB_ARB_PERF_EN
  ,
  output logic [31:0] perf_rd_bursts,
  output logic [31:0] perf_wr_bursts,
  output logic [31:0] perf_urgent_wait
`endif
);
  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int BW = $clog2(BURST_LEN);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN-1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  state_t state, next_state;
  logic [ADDR_W-1:0] cmd_addr;
  logic cmd_write;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic [OW-1:0] outstanding;
  logic err;
  logic idle, credit, grant_rd, grant_wr, cmd_hs, beat_hs, last_beat, rd_inc, rd_dec;
  // rst_n gates arbitration so no ready pulses escape while reset is held
  always_comb begin
    idle = rst_n && state == IDLE;
    credit = outstanding < MAX_OUT;
    grant_rd = idle && bus.rd_req_valid && credit &&
               (bus.rd_urgent || !(bus.wr_req_valid && starve_cnt >= STARVE_MAX));
    grant_wr = idle && bus.wr_req_valid && !grant_rd;
    cmd_hs = state == CMD && bus.mem_cmd_ready;
    beat_hs = state == WDATA && bus.wr_data_valid && bus.mem_wdata_ready;
    last_beat = state == WDATA && beat_cnt == LAST_BEAT;
    rd_inc = cmd_hs && !cmd_write;
    rd_dec = bus.mem_rdata_valid && bus.mem_rdata_last && outstanding != '0;
    next_state = (grant_rd || grant_wr) ? CMD :
                 cmd_hs ? (cmd_write ? WDATA : IDLE) :
                 (beat_hs && last_beat) ? IDLE : state;
    bus.rd_req_ready = grant_rd;
    bus.wr_req_ready = grant_wr;
    bus.mem_cmd_valid = state == CMD;
    bus.mem_cmd_write = cmd_write;
    bus.mem_cmd_addr = cmd_addr;
    bus.mem_wdata = state == WDATA ? bus.wr_data : {DATA_W{1'b0}};
    bus.mem_wdata_valid = state == WDATA && bus.wr_data_valid;
    bus.wr_data_ready = state == WDATA && bus.mem_wdata_ready;
    bus.mem_wdata_last = last_beat;
    bus.rd_outstanding = outstanding;
    bus.err_wlast = err;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_addr <= '0;
      cmd_write <= 1'b0;
      starve_cnt <= '0;
      beat_cnt <= '0;
      outstanding <= '0;
      err <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_rd || grant_wr) begin
        cmd_addr <= grant_rd ? bus.rd_req_addr : bus.wr_req_addr;
        cmd_write <= grant_wr;
      end
      if (grant_wr) starve_cnt <= '0;
      else if (grant_rd && bus.wr_req_valid && starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
      if (cmd_hs) beat_cnt <= '0;
      else if (beat_hs) beat_cnt <= beat_cnt + BW'(1);
      if (rd_inc != rd_dec) outstanding <= rd_inc ? outstanding + OW'(1) : outstanding - OW'(1);
      if (beat_hs && bus.wr_data_last != last_beat) err <= 1'b1;
    end
  end
`ifdef FB_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_bursts <= '0;
      perf_wr_bursts <= '0;
      perf_urgent_wait <= '0;
    end else begin
      if (rd_inc && perf_rd_bursts != '1) perf_rd_bursts <= perf_rd_bursts + 32'd1;
      if (cmd_hs && cmd_write && perf_wr_bursts != '1) perf_wr_bursts <= perf_wr_bursts + 32'd1;
      if (bus.rd_urgent && bus.rd_req_valid && !grant_rd && perf_urgent_wait != '1)
        perf_urgent_wait <= perf_urgent_wait + 32'd1;
    end
  end
`endif
endmodule

// File: doc/framebuffer_dram_arbiter.md
Name: framebuffer_dram_arbiter

Overview:
- Shares one DRAM burst-command port between two video-pipeline requesters.
- Display line-fetch reader: deadline-critical.
- Processed-frame write-back writer: bulk traffic.
- Sits between the video processor's DRAM read/write interfaces and the memory-controller user port.
- Enforces a read-credit limit, urgent-read priority, and a write-starvation bound.

Parameters:
- ADDR_W, 27: DRAM burst address width.
- DATA_W, 128: DRAM data beat width.
- BURST_LEN, 8: beats per burst, fixed, ≥2.
- MAX_OUTSTANDING, 4: maximum read bursts issued but not fully returned.
- STARVE_LIMIT, 4: consecutive read grants allowed while a write is pending.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- rd_req_valid  in  1  read burst request
- rd_req_addr  in  ADDR_W  read burst address
- rd_urgent  in  1  reader FIFO below watermark
- rd_req_ready  out  1  read request accepted this cycle
- wr_req_valid  in  1  write burst request
- wr_req_addr  in  ADDR_W  write burst address
- wr_req_ready  out  1  write request accepted this cycle
- wr_data  in  DATA_W  write beat
- wr_data_valid  in  1  write beat valid
- wr_data_last  in  1  requester's last-beat marker
- wr_data_ready  out  1  write beat accepted
- mem_cmd_valid  out  1  command valid
- mem_cmd_write  out  1  1 = write, 0 = read
- mem_cmd_addr  out  ADDR_W  command address
- mem_cmd_ready  in  1  controller accepts command
- mem_wdata  out  DATA_W  write beat to controller
- mem_wdata_valid  out  1  write beat valid
- mem_wdata_last  out  1  final beat of burst
- mem_wdata_ready  in  1  controller accepts beat
- mem_rdata_valid  in  1  read beat returned (data bypasses this block)
- mem_rdata_last  in  1  final beat of a read burst
- rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  read bursts in flight
- err_wlast  out  1  sticky write-last mismatch

Behaviour:
- FSM states: IDLE, CMD, WDATA.
- Reset: FSM=IDLE. All outputs 0. starve_cnt, beat_cnt, rd_outstanding = 0. err_wlast = 0. Applies immediately, also mid-burst; in-flight bursts are abandoned.
- IDLE arbitration is combinational, in priority order:
  1. rd_req_valid & rd_urgent & credit → read.
  2. wr_req_valid & starve_cnt ≥ STARVE_LIMIT → write.
  3. rd_req_valid & credit → read.
  4. wr_req_valid → write.
  5. Otherwise stay IDLE.
- credit = rd_outstanding < MAX_OUTSTANDING.
- Exactly one of rd_req_ready / wr_req_ready pulses for the winner, in IDLE only. Address and direction are latched; next state is CMD.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on a read grant while wr_req_valid = 1;
  - clears on a write grant;
  - holds otherwise.
- CMD: mem_cmd_valid = 1, mem_cmd_addr/mem_cmd_write held stable until mem_cmd_ready. On handshake: read → IDLE; write → WDATA with beat_cnt = 0.
- Latency: request handshake in cycle N → mem_cmd_valid in cycle N+1. Minimum 2 cycles per command.
- WDATA is a combinational passthrough:
  - mem_wdata = wr_data;
  - mem_wdata_valid = wr_data_valid;
  - wr_data_ready = mem_wdata_ready.
- beat_cnt advances on each beat handshake. mem_wdata_last = (beat_cnt == BURST_LEN-1). After the last-beat handshake → IDLE.
- err_wlast sets on any beat handshake where wr_data_last ≠ mem_wdata_last. It clears only on reset. The burst still completes at BURST_LEN beats.
- Outside WDATA: mem_wdata_valid = 0, wr_data_ready = 0.
- rd_outstanding:
  - +1 on read command handshake;
  - −1 on mem_rdata_valid & mem_rdata_last;
  - both in the same cycle → unchanged;
  - never exceeds MAX_OUTSTANDING, never wraps below 0 (a stray last at 0 is ignored).
- Credit is re-evaluated every IDLE cycle. A returning last beat in cycle N allows a grant in cycle N+1.

Optional Feature:
- Macro: FB_ARB_PERF_EN.
- When defined, adds three 32-bit saturating output counters, cleared by reset:
  - perf_rd_bursts: read command handshakes.
  - perf_wr_bursts: write command handshakes.
  - perf_urgent_wait: cycles with rd_urgent & rd_req_valid & !rd_req_ready.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reads only: rd_req_valid held, mem_cmd_ready = 1, no read returns → exactly 4 read commands issued, then rd_req_ready stays 0. Return one mem_rdata_last → 5th command issued 2 cycles later, rd_outstanding back to 4.
- Starvation: rd_req_valid and wr_req_valid both held, reads returned promptly → grant sequence R,R,R,R,W,R,R,R,R,W.
- Urgent read: starve_cnt = 4 with rd_urgent = 1 → read still wins. Drop rd_urgent → write wins next.
- Write burst with mem_wdata_ready toggling 1,0,1,0… → 8 beats forwarded in order, mem_wdata_last only on beat 7, FSM back in IDLE the cycle after. Inject wr_data_last on beat 3 → err_wlast = 1 and stays 1.
- Same-cycle read command handshake and mem_rdata_last with rd_outstanding = 2 → remains 2.
- Assert rst_n = 0 mid-write at beat 4 → outputs 0 asynchronously. After release, the first grant proceeds normally with rd_outstanding = 0.
